// File: rtl/apb_reg_slave.sv
// APB3 completer over a word-addressed register bank; word 0 is a read-only ID.
// Latency: setup-to-completion WAIT_STATES+2 edges; prdata/pready/pslverr are registered.
// Backpressure: pready is held low for WAIT_STATES cycles, and also while stall=1 when APB_SLV_STALL_EN is defined.
module apb_reg_slave #(
  parameter int unsigned                ADDR_WIDTH  = 32,
  parameter int unsigned                DATA_WIDTH  = 32,
  parameter int unsigned                NUM_REGS    = 16,
  parameter logic [ADDR_WIDTH-1:0]      BASE_ADDR   = '0,
  parameter int unsigned                WAIT_STATES = 2,
  parameter logic [DATA_WIDTH-1:0]      ID_VALUE    = DATA_WIDTH'(32'hA9B0_0001)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           psel,
  input  logic                           penable,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic                           pwrite,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
`ifdef APB_SLV_STALL_EN
  ,
  input  logic                           stall
`endif
);

  localparam int unsigned           IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(NUM_REGS * 4);
  localparam logic [7:0]            WS8   = 8'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state;
  logic [7:0]              wait_cnt;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]   lat_wdata;
  logic                    lat_write;
  logic [DATA_WIDTH-1:0]   regs [1:NUM_REGS-1];
  logic                    stall_hold;

`ifdef APB_SLV_STALL_EN
  assign stall_hold = stall;
`else
  assign stall_hold = 1'b0;
`endif

  logic [ADDR_WIDTH-1:0]   dec_addr;
  logic [ADDR_WIDTH-1:0]   dec_off;
  logic                    dec_write;
  logic                    dec_legal;
  logic                    dec_err;
  logic [IDX_W-1:0]        dec_idx;
  logic [DATA_WIDTH-1:0]   dec_rdata;
  logic                    commit;

  // In IDLE the bus is decoded directly so a zero-wait transfer can respond on the setup edge.
  always_comb begin
    dec_addr  = (state == S_IDLE) ? paddr  : lat_addr;
    dec_write = (state == S_IDLE) ? pwrite : lat_write;
    dec_off   = dec_addr - BASE_ADDR;
    dec_legal = (dec_addr[1:0] == 2'b00) && (dec_off < SPAN);
    dec_idx   = dec_off[IDX_W+1:2];
    dec_err   = !dec_legal || (dec_write && (dec_idx == '0));
    dec_rdata = (dec_legal && !dec_write) ? reg_q[dec_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  assign commit = (state == S_RESP) && psel && penable && lat_write && !dec_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int i = 1; i < NUM_REGS; i++)
        if (dec_idx == IDX_W'(i)) regs[i] <= lat_wdata;
    end
  end

  assign reg_q[0 +: DATA_WIDTH] = ID_VALUE;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_q
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      prdata    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (psel && !penable) begin
            lat_addr  <= paddr;
            lat_wdata <= pwdata;
            lat_write <= pwrite;
            wait_cnt  <= WS8;
            if (WS8 == 8'd0) begin
              state   <= S_RESP;
              pready  <= 1'b1;
              pslverr <= dec_err;
              prdata  <= dec_rdata;
            end else begin
              state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!psel) begin
            state <= S_IDLE;
          end else if (!stall_hold) begin
            wait_cnt <= wait_cnt - 8'd1;
            if (wait_cnt == 8'd1) begin
              state   <= S_RESP;
              pready  <= 1'b1;
              pslverr <= dec_err;
              prdata  <= dec_rdata;
            end
          end
        end
        S_RESP: begin
          // Completion (psel&penable) and abort (!psel) both return to IDLE; only completion commits.
          if (!psel || penable) begin
            state   <= S_IDLE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: a 2-wait instance and a 0-wait instance share one APB bus.
module tb_apb_reg_slave;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] ID   = 32'hA9B0_0001;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         psel = 1'b0;
  logic         tgt0 = 1'b0;
  logic         penable = 1'b0;
  logic         pwrite = 1'b0;
  logic [31:0]  paddr = '0;
  logic [31:0]  pwdata = '0;
  logic         psel2, psel0;
  logic [31:0]  prdata2, prdata0;
  logic         pready2, pready0, pslverr2, pslverr0;
  logic [511:0] reg_q2, reg_q0;
`ifdef APB_SLV_STALL_EN
  logic         stall = 1'b0;
  logic         stall0 = 1'b0;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  assign psel2 = psel & ~tgt0;
  assign psel0 = psel & tgt0;

  apb_reg_slave #(.WAIT_STATES(2), .BASE_ADDR(BASE)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .psel(psel2), .penable(penable), .paddr(paddr),
    .pwdata(pwdata), .pwrite(pwrite), .prdata(prdata2), .pready(pready2),
    .pslverr(pslverr2), .reg_q(reg_q2)
`ifdef APB_SLV_STALL_EN
    , .stall(stall)
`endif
  );

  apb_reg_slave #(.WAIT_STATES(0), .BASE_ADDR(BASE)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .psel(psel0), .penable(penable), .paddr(paddr),
    .pwdata(pwdata), .pwrite(pwrite), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0), .reg_q(reg_q0)
`ifdef APB_SLV_STALL_EN
    , .stall(stall0)
`endif
  );

  // Called #1 after a rising edge; drives setup immediately so chained calls run back-to-back.
  task automatic apb_xfer(input logic z, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int budget,
                          output logic [31:0] rdata, output logic err,
                          output int cyc, output logic tout);
    logic rdy;
    tgt0 = z; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc = 1; tout = 1'b0;
    rdy = z ? pready0 : pready2;
    while (!rdy && !tout) begin
      if (cyc >= budget) begin
        tout = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
        rdy = z ? pready0 : pready2;
      end
    end
    if (tout) begin
      rdata = '0; err = 1'b0; cyc = budget + 1;
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
    end else begin
      rdata = z ? prdata0 : prdata2;
      err   = z ? pslverr0 : pslverr2;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [511:0] exp_q;
    exp_q = '0; exp_q[31:0] = ID;
    vectors++; if (pready2 !== 1'b0) begin errors++; $display("FAIL reset_pready got %b want 0", pready2); end
    vectors++; if (pslverr2 !== 1'b0) begin errors++; $display("FAIL reset_pslverr got %b want 0", pslverr2); end
    vectors++; if (prdata2 !== 32'h0) begin errors++; $display("FAIL reset_prdata got %h want 0", prdata2); end
    vectors++; if (reg_q2 !== exp_q) begin errors++; $display("FAIL reset_regq2 got %h want %h", reg_q2, exp_q); end
    vectors++; if (reg_q0 !== exp_q) begin errors++; $display("FAIL reset_regq0 got %h want %h", reg_q0, exp_q); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic err; int cyc; logic to;
    apb_xfer(1'b0, 1'b1, BASE + 32'hC, 32'h1234_5678, 20, rd, err, cyc, to);
    vectors++; if (cyc !== 3) begin errors++; $display("FAIL wr_access_cycles got %0d want 3", cyc); end
    vectors++; if (err !== 1'b0) begin errors++; $display("FAIL wr_pslverr got %b want 0", err); end
    vectors++; if (reg_q2[3*32 +: 32] !== 32'h1234_5678) begin errors++; $display("FAIL wr_regq3 got %h want 12345678", reg_q2[3*32 +: 32]); end
    apb_xfer(1'b0, 1'b0, BASE + 32'hC, 32'h0, 20, rd, err, cyc, to);
    vectors++; if (cyc !== 3) begin errors++; $display("FAIL rd_access_cycles got %0d want 3", cyc); end
    vectors++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL rd_data got %h want 12345678", rd); end
    vectors++; if (err !== 1'b0) begin errors++; $display("FAIL rd_pslverr got %b want 0", err); end
  endtask

  task automatic test_id_reg();
    logic [31:0] rd; logic err; int cyc; logic to;
    apb_xfer(1'b0, 1'b0, BASE, 32'h0, 20, rd, err, cyc, to);
    vectors++; if (rd !== ID || err !== 1'b0) begin errors++; $display("FAIL id_read got %h/%b want %h/0", rd, err, ID); end
    apb_xfer(1'b0, 1'b1, BASE, 32'hFFFF_FFFF, 20, rd, err, cyc, to);
    vectors++; if (err !== 1'b1 || cyc !== 3) begin errors++; $display("FAIL id_write got err %b cyc %0d want 1/3", err, cyc); end
    apb_xfer(1'b0, 1'b0, BASE, 32'h0, 20, rd, err, cyc, to);
    vectors++; if (rd !== ID || err !== 1'b0) begin errors++; $display("FAIL id_reread got %h/%b want %h/0", rd, err, ID); end
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic err; int cyc; logic to;
    logic [511:0] exp_q;
    exp_q = '0; exp_q[31:0] = ID; exp_q[3*32 +: 32] = 32'h1234_5678;
    apb_xfer(1'b0, 1'b0, BASE + 32'h40, 32'h0, 20, rd, err, cyc, to);
    vectors++; if (rd !== 32'h0 || err !== 1'b1) begin errors++; $display("FAIL oob_read got %h/%b want 0/1", rd, err); end
    apb_xfer(1'b0, 1'b0, BASE - 32'h4, 32'h0, 20, rd, err, cyc, to);
    vectors++; if (rd !== 32'h0 || err !== 1'b1) begin errors++; $display("FAIL below_base_read got %h/%b want 0/1", rd, err); end
    apb_xfer(1'b0, 1'b1, BASE + 32'h6, 32'hDEAD_BEEF, 20, rd, err, cyc, to);
    vectors++; if (err !== 1'b1) begin errors++; $display("FAIL misaligned_write err got %b want 1", err); end
    vectors++; if (reg_q2 !== exp_q) begin errors++; $display("FAIL misaligned_bank got %h want %h", reg_q2, exp_q); end
    apb_xfer(1'b0, 1'b1, BASE + 32'h3C, 32'hCAFE_F00D, 20, rd, err, cyc, to);
    apb_xfer(1'b0, 1'b0, BASE + 32'h3C, 32'h0, 20, rd, err, cyc, to);
    vectors++; if (rd !== 32'hCAFE_F00D || err !== 1'b0) begin errors++; $display("FAIL last_word got %h/%b want cafef00d/0", rd, err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int cyc; logic to;
    logic [31:0] vals [4];
    vals = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    for (int i = 0; i < 4; i++) begin
      apb_xfer(1'b1, 1'b1, BASE + 32'(4*(i+1)), vals[i], 20, rd, err, cyc, to);
      vectors++; if (cyc !== 1 || err !== 1'b0) begin errors++; $display("FAIL b2b_write%0d got cyc %0d err %b want 1/0", i+1, cyc, err); end
    end
    for (int i = 0; i < 4; i++) begin
      apb_xfer(1'b1, 1'b0, BASE + 32'(4*(i+1)), 32'h0, 20, rd, err, cyc, to);
      vectors++; if (rd !== vals[i] || cyc !== 1) begin errors++; $display("FAIL b2b_read%0d got %h cyc %0d want %h/1", i+1, rd, cyc, vals[i]); end
    end
    vectors++; if (reg_q0[4*32 +: 32] !== 32'h4444_0004) begin errors++; $display("FAIL b2b_regq4 got %h want 44440004", reg_q0[4*32 +: 32]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int cyc; logic to;
    tgt0 = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h14; pwdata = 32'h55AA_55AA;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    #2 reset_n = 1'b0;
    #1;
    vectors++; if (pready2 !== 1'b0 || pslverr2 !== 1'b0) begin errors++; $display("FAIL midrst_outputs got %b/%b want 0/0", pready2, pslverr2); end
    vectors++; if (reg_q2[3*32 +: 32] !== 32'h0) begin errors++; $display("FAIL midrst_bank_clear got %h want 0", reg_q2[3*32 +: 32]); end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    apb_xfer(1'b0, 1'b0, BASE + 32'h14, 32'h0, 20, rd, err, cyc, to);
    vectors++; if (rd !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL midrst_idx5 got %h/%b want 0/0", rd, err); end
  endtask

`ifdef APB_SLV_STALL_EN
  task automatic test_stall();
    logic [31:0] rd; logic err; int cyc; logic to;
    stall = 1'b1;
    apb_xfer(1'b0, 1'b1, BASE + 32'h18, 32'h6666_6666, 100, rd, err, cyc, to);
    vectors++; if (to !== 1'b1) begin errors++; $display("FAIL stall_timeout got %b want 1", to); end
    vectors++; if (pready2 !== 1'b0) begin errors++; $display("FAIL stall_abort_pready got %b want 0", pready2); end
    stall = 1'b0;
    apb_xfer(1'b0, 1'b0, BASE + 32'h18, 32'h0, 20, rd, err, cyc, to);
    vectors++; if (cyc !== 3 || rd !== 32'h0) begin errors++; $display("FAIL stall_release got cyc %0d data %h want 3/0", cyc, rd); end
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_id_reg();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
`ifdef APB_SLV_STALL_EN
    test_stall();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/apb_reg_slave.md
# apb_reg_slave

APB3 completer that terminates the bus driven by the emulation APB transactor and backs it with a small word-addressed register bank. It decodes each transfer, inserts a fixed number of wait states, commits writes, returns read data, and flags illegal accesses on `pslverr`. The register bank is exported flat so DUT-side logic and monitors can observe the programmed values.

## Interface
- `ADDR_WIDTH`, 32, APB address width.
- `DATA_WIDTH`, 32, APB data width; the register width.
- `NUM_REGS`, 16, number of 32-bit words; a power of two, 2..256.
- `BASE_ADDR`, 0, byte base of the bank; aligned to `NUM_REGS*4`.
- `WAIT_STATES`, 2, access-phase cycles with `pready` low per transfer, 0..255.
- `ID_VALUE`, 32'hA9B0_0001, constant returned by register 0.

Ports:
- `clk` input 1: single clock; all logic on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `psel` input 1: APB select.
- `penable` input 1: APB enable (access phase).
- `paddr` input `ADDR_WIDTH`: byte address.
- `pwdata` input `DATA_WIDTH`: write data.
- `pwrite` input 1: 1 = write, 0 = read.
- `prdata` output `DATA_WIDTH`: read data, registered; valid only while `pready`=1.
- `pready` output 1: transfer-complete, registered.
- `pslverr` output 1: error, registered; valid only while `pready`=1, otherwise 0.
- `reg_q` output `NUM_REGS*DATA_WIDTH`: flat register bank; word i at bits [i*DATA_WIDTH +: DATA_WIDTH]; word 0 reads as `ID_VALUE`.
- `stall` input 1: present only with `APB_SLV_STALL_EN`; holds off completion.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: on an edge with `psel`=1, `penable`=0 (setup), latch `paddr`, `pwrite`, `pwdata`. Load `wait_cnt` (8 bit) = `WAIT_STATES`. Go to WAIT if `WAIT_STATES`>0, else RESP.
- WAIT: `pready`=0. Decrement `wait_cnt` each edge. At `wait_cnt`==1, go to RESP.
- RESP: `pready`=1, plus `prdata` and `pslverr` for the latched transfer. The transfer completes on the edge where `psel`&`penable`&`pready`. Go to IDLE.
- Decode uses `off = paddr - BASE_ADDR`:
  - Legal when `paddr[1:0]`==0 and `off` < `NUM_REGS*4`.
  - Index = `off[IDX_W+1:2]`.
- Write, legal index 1..N-1: `pwdata` is committed at the completion edge. `pslverr`=0.
- Write to index 0, misaligned address, or out of range: no state change, `pslverr`=1.
- Read, legal: `prdata` = word, or `ID_VALUE` for index 0. `pslverr`=0.
- Read, illegal: `prdata`=0, `pslverr`=1.
- Abort: if `psel` falls while in WAIT or RESP, go to IDLE with no commit. `pready`, `pslverr` and `prdata` drop to 0 next cycle.
- `penable` high in IDLE without a prior setup is ignored.

## Timing
- Reset (async assert, sync deassert at the bench): state IDLE, `wait_cnt`=0, `pready`=0, `pslverr`=0, `prdata`=0, registers 1..N-1 = 0.
- Access phase lasts exactly `WAIT_STATES`+1 cycles. `pready` is high only in the last of them.
- `WAIT_STATES`=0: `pready` is high in the first access cycle (zero-wait APB).
- Setup-to-completion latency: `WAIT_STATES`+2 edges.
- Back-to-back: a setup on the cycle after completion is accepted. There are no dead cycles.
- `reg_q` updates on the completion edge of a write.
- Reset mid-transfer: all outputs clear immediately and any pending write is discarded.

## Configuration
- `APB_SLV_STALL_EN`:
  - Defined: the `stall` port exists. While `stall`=1, the FSM holds in WAIT with `pready`=0 and `wait_cnt` frozen. When `stall` falls, the countdown resumes. Used to exercise the master bus timeout.
  - Undefined: there is no `stall` port and wait states are fixed.

## Test plan
- `WAIT_STATES`=2: write 0x1234_5678 to `BASE_ADDR`+0xC, then read it back. Required: `pready` low for 2 access cycles and high on the 3rd; read returns 0x1234_5678 with `pslverr`=0; `reg_q` word 3 = 0x1234_5678.
- Read `BASE_ADDR`+0 -> `ID_VALUE`, `pslverr`=0. Write 0xFFFF_FFFF to `BASE_ADDR`+0 -> `pslverr`=1; a following read still returns `ID_VALUE`.
- Read `BASE_ADDR`+0x40 with `NUM_REGS`=16 -> `prdata`=0, `pslverr`=1. Write to `BASE_ADDR`+0x6 -> `pslverr`=1 and no register changes.
- `WAIT_STATES`=0: 4 back-to-back writes to indices 1..4 -> each completes in 2 cycles and all four values read back.
- Assert `reset_n`=0 during WAIT of a write to index 5 -> `pready`=0 at once; index 5 reads 0 after reset.
- `APB_SLV_STALL_EN` defined, `stall`=1 held -> master times out after 100 cycles with its error response. Release `stall` on the next transfer -> it completes after `WAIT_STATES`+1 access cycles.
